// File: rtl/spectrum_pkg.sv
// Shared constants, FSM encoding and the power-to-height mapping for the
// spectrum peak meter.
package spectrum_pkg;

    localparam int NUM_BANDS   = 6;
    localparam int PWR_W       = 11;
    localparam int HEIGHT_W    = 9;
    localparam int BAND_W      = 3;
    localparam int SCALE_SHIFT = 2;
    localparam int HOLD_W      = 5;

    localparam logic [HEIGHT_W-1:0] MAX_HEIGHT = 9'd400;
    localparam logic [HEIGHT_W-1:0] DECAY_STEP = 9'd4;
    localparam logic [HOLD_W-1:0]   HOLD_TICKS = 5'd24;
    localparam logic [BAND_W-1:0]   LAST_BAND  = 3'(NUM_BANDS - 1);
    localparam logic [BAND_W-1:0]   BAND_COUNT = 3'(NUM_BANDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The shifted power is exactly HEIGHT_W bits wide, so only the clamp remains.
    function automatic logic [HEIGHT_W-1:0] power_to_height(input logic [PWR_W-1:0] p);
        logic [HEIGHT_W-1:0] scaled;
        scaled = p[PWR_W-1:SCALE_SHIFT];
        return (scaled > MAX_HEIGHT) ? MAX_HEIGHT : scaled;
    endfunction

endpackage

// File: rtl/band_ballistics.sv
// Combinational meter ballistics for one band: instant attack, linear decay,
// and a peak marker that holds before decaying (never below the level).
module band_ballistics
    import spectrum_pkg::*;
(
    input  logic [HEIGHT_W-1:0] h_i,
    input  logic [HEIGHT_W-1:0] level_i,
    input  logic [HEIGHT_W-1:0] peak_i,
    input  logic [HOLD_W-1:0]   hold_i,
    output logic [HEIGHT_W-1:0] level_o,
    output logic [HEIGHT_W-1:0] peak_o,
    output logic [HOLD_W-1:0]   hold_o
);

    logic [HEIGHT_W-1:0] level_dec;
    logic [HEIGHT_W-1:0] peak_dec;

    always_comb begin
        level_dec = (level_i >= DECAY_STEP) ? (level_i - DECAY_STEP) : '0;
        peak_dec  = (peak_i  >= DECAY_STEP) ? (peak_i  - DECAY_STEP) : '0;

        if (h_i >= level_i) begin
            level_o = h_i;
        end else begin
            level_o = (level_dec > h_i) ? level_dec : h_i;
        end

        if (h_i >= peak_i) begin
            peak_o = h_i;
            hold_o = HOLD_TICKS;
        end else if (hold_i != '0) begin
            peak_o = peak_i;
            hold_o = hold_i - HOLD_W'(1);
        end else begin
            // Decaying peak is pulled up to the new level so it never sits below the bar.
            peak_o = (peak_dec > level_o) ? peak_dec : level_o;
            hold_o = '0;
        end
    end

endmodule

// File: rtl/spectrum_peak_meter.sv
// Per-frame bar-height updater for the six-band spectrum display, with a
// registered random-access read port for the VGA renderer.
module spectrum_peak_meter
    import spectrum_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_BANDS*PWR_W-1:0]    power_bus,
    input  logic [BAND_W-1:0]             rd_band,
    output logic [HEIGHT_W-1:0]           rd_level,
    output logic [HEIGHT_W-1:0]           rd_peak,
    output logic                          busy,
    output logic                          update_done,
    output logic                          overrun
);

    state_t state_q, state_d;
    logic [BAND_W-1:0]          band_q, band_d;
    logic [NUM_BANDS*PWR_W-1:0] shadow_q;

    logic [PWR_W-1:0]    pwr_q;
    logic [HEIGHT_W-1:0] cur_level_q;
    logic [HEIGHT_W-1:0] cur_peak_q;
    logic [HOLD_W-1:0]   cur_hold_q;

    logic [HEIGHT_W-1:0] level_q [NUM_BANDS];
    logic [HEIGHT_W-1:0] peak_q  [NUM_BANDS];
    logic [HOLD_W-1:0]   hold_q  [NUM_BANDS];

    logic [HEIGHT_W-1:0] rd_level_q;
    logic [HEIGHT_W-1:0] rd_peak_q;
    logic                overrun_q;

    logic [HEIGHT_W-1:0] h;
    logic [HEIGHT_W-1:0] new_level;
    logic [HEIGHT_W-1:0] new_peak;
    logic [HOLD_W-1:0]   new_hold;

    assign h = power_to_height(pwr_q);

    band_ballistics u_ballistics (
        .h_i     (h),
        .level_i (cur_level_q),
        .peak_i  (cur_peak_q),
        .hold_i  (cur_hold_q),
        .level_o (new_level),
        .peak_o  (new_peak),
        .hold_o  (new_hold)
    );

    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        case (state_q)
            ST_IDLE:  if (tick) state_d = ST_LATCH;
            ST_LATCH: begin
                band_d  = '0;
                state_d = ST_RD;
            end
            ST_RD:    state_d = ST_WR;
            ST_WR: begin
                if (band_q == LAST_BAND) begin
                    state_d = ST_DONE;
                end else begin
                    band_d  = band_q + BAND_W'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            band_q      <= '0;
            shadow_q    <= '0;
            pwr_q       <= '0;
            cur_level_q <= '0;
            cur_peak_q  <= '0;
            cur_hold_q  <= '0;
            rd_level_q  <= '0;
            rd_peak_q   <= '0;
            overrun_q   <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                level_q[b] <= '0;
                peak_q[b]  <= '0;
                hold_q[b]  <= '0;
            end
        end else begin
            state_q <= state_d;
            band_q  <= band_d;

            if (state_q == ST_LATCH) begin
                shadow_q <= power_bus;
            end

            if (state_q == ST_RD) begin
                pwr_q       <= shadow_q[band_q*PWR_W +: PWR_W];
                cur_level_q <= level_q[band_q];
                cur_peak_q  <= peak_q[band_q];
                cur_hold_q  <= hold_q[band_q];
            end

            if (state_q == ST_WR) begin
                level_q[band_q] <= new_level;
                peak_q[band_q]  <= new_peak;
                hold_q[band_q]  <= new_hold;
            end

            // Any tick outside IDLE (DONE included) is dropped and flagged.
            if (tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end

            // Reads see the array before any same-cycle write lands.
            if (rd_band < BAND_COUNT) begin
                rd_level_q <= level_q[rd_band];
                rd_peak_q  <= peak_q[rd_band];
            end else begin
                rd_level_q <= '0;
                rd_peak_q  <= '0;
            end
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign update_done = (state_q == ST_DONE);
    assign overrun     = overrun_q;
    assign rd_level    = rd_level_q;
    assign rd_peak     = rd_peak_q;

endmodule

// File: tb/tb_spectrum_peak_meter.sv
// Directed self-checking bench for spectrum_peak_meter: pass timing, decay and
// hold ballistics, clamping, overrun, mid-pass reset and read-port latency.
module tb_spectrum_peak_meter;
    import spectrum_pkg::*;

    localparam int BUS_W = NUM_BANDS * PWR_W;

    logic                clk = 1'b0;
    logic                reset;
    logic                tick;
    logic [BUS_W-1:0]    power_bus;
    logic [BAND_W-1:0]   rd_band;
    logic [HEIGHT_W-1:0] rd_level;
    logic [HEIGHT_W-1:0] rd_peak;
    logic                busy;
    logic                update_done;
    logic                overrun;

    int errors = 0;
    int checks = 0;

    logic [HEIGHT_W-1:0] hist_l    [0:20];
    logic [HEIGHT_W-1:0] hist_p    [0:20];
    logic                hist_busy [0:20];
    int                  done_at;
    int                  done_cnt;
    logic [HEIGHT_W-1:0] lv, pk;
    logic [BUS_W-1:0]    swap_bus;

    always #5 clk = ~clk;

    spectrum_peak_meter dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .power_bus   (power_bus),
        .rd_band     (rd_band),
        .rd_level    (rd_level),
        .rd_peak     (rd_peak),
        .busy        (busy),
        .update_done (update_done),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_band(input int b, input int v);
        power_bus[b*PWR_W +: PWR_W] = PWR_W'(v);
    endtask

    task automatic read_band(input int b, output logic [HEIGHT_W-1:0] l, output logic [HEIGHT_W-1:0] p);
        @(negedge clk);
        rd_band = BAND_W'(b);
        @(negedge clk);
        l = rd_level;
        p = rd_peak;
    endtask

    // Tick is sampled at the end of cycle T; index j of the history is cycle T+j.
    task automatic run_pass(input int second_tick_at, input int reset_at,
                            input int swap_at, input logic [BUS_W-1:0] alt_bus);
        done_at  = -1;
        done_cnt = 0;
        @(negedge clk);
        tick = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            tick = 1'b0;
            hist_l[j]    = rd_level;
            hist_p[j]    = rd_peak;
            hist_busy[j] = busy;
            if (update_done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (reset_at > 0 && j == reset_at + 1) reset = 1'b0;
            if (j == reset_at) reset = 1'b1;
            if (j == second_tick_at) tick = 1'b1;
            if (j == swap_at) power_bus = alt_bus;
        end
    endtask

    initial begin
        reset     = 1'b1;
        tick      = 1'b0;
        power_bus = '0;
        rd_band   = '0;
        swap_bus  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", update_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_level", rd_level, 0);
        check("rst_rd_peak", rd_peak, 0);

        // Single pass: band0 power 800 -> 200
        set_band(0, 800);
        run_pass(0, 0, 0, swap_bus);
        check("p1_done_at", done_at, 14);
        check("p1_done_cnt", done_cnt, 1);
        check("p1_busy_first", hist_busy[1], 1);
        check("p1_busy_last", hist_busy[14], 1);
        check("p1_busy_after", hist_busy[15], 0);
        read_band(0, lv, pk);
        check("p1_b0_level", lv, 200);
        check("p1_b0_peak", pk, 200);
        read_band(1, lv, pk);
        check("p1_b1_level", lv, 0);
        read_band(5, lv, pk);
        check("p1_b5_peak", pk, 0);

        // Decay with hold: 24 held ticks, decay begins on the 25th
        power_bus = '0;
        for (int i = 0; i < 24; i++) run_pass(0, 0, 0, swap_bus);
        read_band(0, lv, pk);
        check("hold24_level", lv, 104);
        check("hold24_peak", pk, 200);
        run_pass(0, 0, 0, swap_bus);
        read_band(0, lv, pk);
        check("tick25_level", lv, 100);
        check("tick25_peak", pk, 196);
        run_pass(0, 0, 0, swap_bus);
        read_band(0, lv, pk);
        check("tick26_level", lv, 96);
        check("tick26_peak", pk, 192);

        // Clamp and no-underflow
        set_band(5, 2047);
        set_band(3, 8);
        run_pass(0, 0, 0, swap_bus);
        read_band(5, lv, pk);
        check("clamp_level", lv, 400);
        check("clamp_peak", pk, 400);
        read_band(3, lv, pk);
        check("b3_level_2", lv, 2);
        set_band(3, 0);
        run_pass(0, 0, 0, swap_bus);
        read_band(3, lv, pk);
        check("b3_no_wrap", lv, 0);
        check("b3_peak_held", pk, 2);

        // Overrun: second tick at T+5
        check("pre_overrun", overrun, 0);
        run_pass(5, 0, 0, swap_bus);
        check("ovr_done_cnt", done_cnt, 1);
        check("ovr_done_at", done_at, 14);
        check("ovr_flag", overrun, 1);
        run_pass(0, 0, 0, swap_bus);
        check("ovr_next_done", done_cnt, 1);
        check("ovr_sticky", overrun, 1);

        // Reset mid-pass at T+6
        run_pass(0, 6, 0, swap_bus);
        check("rst_mid_busy", hist_busy[7], 0);
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_overrun", overrun, 0);
        read_band(5, lv, pk);
        check("rst_mid_b5_level", lv, 0);
        check("rst_mid_b5_peak", pk, 0);
        read_band(0, lv, pk);
        check("rst_mid_b0_level", lv, 0);

        // Fresh pass with a tick landing in the DONE cycle
        power_bus = '0;
        set_band(1, 100);
        run_pass(14, 0, 0, swap_bus);
        check("fresh_done_at", done_at, 14);
        check("fresh_done_cnt", done_cnt, 1);
        check("done_tick_overrun", overrun, 1);
        read_band(1, lv, pk);
        check("fresh_b1_level", lv, 25);
        check("fresh_b1_peak", pk, 25);

        // Read port around the WR of band 2 (cycle T+7)
        power_bus = '0;
        set_band(2, 400);
        rd_band = 3'd2;
        run_pass(0, 0, 0, swap_bus);
        check("rdw_old", hist_l[8], 0);
        check("rdw_new", hist_l[9], 100);
        check("rdw_new_peak", hist_p[9], 100);

        // Second pass: bus changes after LATCH must not leak in
        power_bus = '0;
        set_band(2, 40);
        swap_bus = '0;
        swap_bus[2*PWR_W +: PWR_W] = 11'd2000;
        run_pass(0, 0, 2, swap_bus);
        check("rdw2_old", hist_l[8], 100);
        check("rdw2_new_level", hist_l[9], 96);
        check("rdw2_new_peak", hist_p[9], 100);

        read_band(7, lv, pk);
        check("oob7_level", lv, 0);
        check("oob7_peak", pk, 0);
        read_band(6, lv, pk);
        check("oob6_level", lv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
